seg_page_scheduler: RTL and testbench
=====================================

Name: seg_page_scheduler

Overview:
- Sequences what the two-digit seven-segment display shows by driving the 8-bit `value` input of seg_display.
- Rotates between a heart-rate page (BPM as 2-digit BCD) and a mode page.
- Preempts the rotation with an alert page through a req/ack handshake.
- Contains a multi-cycle binary-to-BCD converter (sequential double-dabble), so the top level feeds raw binary BPM.

Parameters:
- DWELL_CYCLES, 24000000, clocks each rotating page is shown (2 s @ 12 MHz).
- ALERT_CYCLES, 12000000, clocks the alert page is shown (1 s @ 12 MHz).

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  asynchronous reset, active-high.
- bpm  in  8  binary heart rate, 0..255.
- bpm_valid  in  1  1-cycle strobe: bpm holds a new sample.
- mode  in  4  current operating mode code.
- hold  in  1  level: freeze BPM/MODE rotation.
- alert_req  in  1  level: request alert page.
- alert_code  in  8  two hex digits to show on alert; sampled at acceptance.
- alert_ack  out  1  1-cycle pulse: alert accepted.
- value  out  8  registered digits to seg_display ([7:4] left digit, [3:0] right digit).
- page  out  2  current page: 0 BPM, 1 MODE, 2 ALERT.
- bcd_busy  out  1  converter running.

Behaviour:
Reset (async, rst=1):
- state SHOW_BPM; dwell counter 0.
- value 8'h00, page 0, alert_ack 0, bcd_busy 0.
- bcd_reg 8'h00, pending flag 0.

BCD converter:
- Idle with bpm_valid=1: latch bpm, set bcd_busy next edge.
- Runs exactly 8 shift iterations, one per clock, with add-3 on any nibble ≥5 before each shift.
- On the 8th iteration edge: write bcd_reg and clear bcd_busy. Latency from bpm_valid to bcd_reg update is 9 clocks.
- Hundreds digit ≠0 → bcd_reg = 8'h99 (saturate).
- bpm_valid while busy: store bpm in a pending register (last wins). Restart on the clock after completion.
- bpm_valid in the completion cycle: treated as pending.

FSM states:
- SHOW_BPM: value ← bcd_reg, page 0.
- SHOW_MODE: value ← {4'hC, mode}, page 1.
- SHOW_ALERT: value ← latched alert_code, page 2.
- value and page are registered, so they reflect state or data one clock later. A bcd_reg change appears on value the next clock while in SHOW_BPM.

Dwell counter:
- Increments every clock in BPM/MODE unless hold=1 (frozen, not cleared).
- At DWELL_CYCLES−1 it toggles BPM↔MODE and clears.
- Cleared on every state entry.

Alert handshake:
- In BPM/MODE with alert_req=1: next edge enters SHOW_ALERT, latches alert_code, and pulses alert_ack high for exactly 1 clock.
- Alert preempts the dwell; a simultaneous dwell expiry is discarded.
- In SHOW_ALERT the counter counts to ALERT_CYCLES−1 regardless of hold, then returns to SHOW_BPM with the counter cleared.
- alert_req during SHOW_ALERT is ignored and not acked.
- If alert_req is still high in the first cycle after return, it is re-accepted. Requesters must drop req after ack.
- alert_code changes after ack do not affect the displayed value.

Other rules:
- Converter runs independently of the FSM.
- Reset mid-conversion or mid-alert aborts immediately. Nothing is retained, including the pending sample.
- No combinational path from inputs to outputs.

Test Plan:
(All scenarios use DWELL_CYCLES=20, ALERT_CYCLES=10, clk 83.333 ns.)
1. Reset, then bpm=8'd72 with a 1-clock bpm_valid → bcd_busy high for 8 clocks; value=8'h72 on clock 10 after the strobe; page=0.
2. bpm=8'd150 strobe → value=8'h99. Then bpm=8'd9 → value=8'h09.
3. Strobe bpm=8'd60, then strobe bpm=8'd61 three clocks later, then 8'd88 two clocks after that → only the 88 conversion restarts after the first completes; value sequence 8'h60 then 8'h88; 61 never shown.
4. Idle with mode=4'h3 → after 20 clocks page=1, value=8'hC3; after 20 more, page=0. With hold=1 for 15 clocks mid-dwell, the toggle is delayed by exactly 15 clocks.
5. alert_req=1, alert_code=8'hE1 in SHOW_MODE → alert_ack pulses one clock; value=8'hE1, page=2 for 10 clocks, then page=0. Changing alert_code to 8'h00 during the alert leaves value=8'hE1.
6. Hold alert_req high continuously → ack once per alert, with re-entry the first clock after return. Assert rst mid-alert → value=8'h00, page=0, alert_ack=0 immediately (asynchronous).

Source files
------------

// File: rtl/seg_page_scheduler.sv
// Picks what the two-digit seven-segment display shows: a BPM page, a mode page, and an alert
// page that preempts them. A serial double-dabble converter turns the binary BPM into BCD.
module seg_page_scheduler #(
    parameter int unsigned DWELL_CYCLES = 24000000,
    parameter int unsigned ALERT_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bpm,
    input  logic       bpm_valid,
    input  logic [3:0] mode,
    input  logic       hold,
    input  logic       alert_req,
    input  logic [7:0] alert_code,
    output logic       alert_ack,
    output logic [7:0] value,
    output logic [1:0] page,
    output logic       bcd_busy
);
    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW_BPM   = 2'd0,
        SHOW_MODE  = 2'd1,
        SHOW_ALERT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       code_q, code_d;
    logic             ack_q, ack_d;
    logic [7:0]       value_q, value_d;
    logic [1:0]       page_q, page_d;

    logic [7:0]       bin_q, bin_d;
    logic [11:0]      work_q, work_d;
    logic [2:0]       iter_q, iter_d;
    logic             busy_q, busy_d;
    logic [7:0]       bcd_reg_q, bcd_reg_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_val_q, pend_val_d;

    logic [11:0]      work_adj;
    logic [19:0]      dd_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Converter: one add-3-then-shift iteration per clock while busy.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        bin_d      = bin_q;
        work_d     = work_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        bcd_reg_d  = bcd_reg_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        work_adj   = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
        dd_next    = {work_adj, bin_q} << 1;

        if (busy_q) begin
            work_d = dd_next[19:8];
            bin_d  = dd_next[7:0];
            iter_d = iter_q + 3'd1;
            if (bpm_valid) begin
                pend_d     = 1'b1;
                pend_val_d = bpm;
            end
            if (iter_q == 3'd7) begin
                busy_d    = 1'b0;
                bcd_reg_d = (dd_next[19:16] != 4'd0) ? 8'h99 : dd_next[15:8];
            end
        end else if (bpm_valid || pend_q) begin
            // A fresh strobe in the idle gap supersedes the stored sample.
            bin_d  = bpm_valid ? bpm : pend_val_q;
            work_d = '0;
            iter_d = '0;
            busy_d = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ack_d   = 1'b0;

        case (state_q)
            SHOW_BPM, SHOW_MODE: begin
                if (alert_req) begin
                    state_d = SHOW_ALERT;
                    cnt_d   = '0;
                    code_d  = alert_code;
                    ack_d   = 1'b1;
                end else if (!hold) begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = (state_q == SHOW_BPM) ? SHOW_MODE : SHOW_BPM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SHOW_ALERT: begin
                if (cnt_q == ALERT_LAST) begin
                    state_d = SHOW_BPM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SHOW_BPM;
                cnt_d   = '0;
            end
        endcase

        // Display registers follow the page in effect during the current cycle.
        case (state_q)
            SHOW_MODE: begin
                value_d = {4'hC, mode};
                page_d  = 2'd1;
            end
            SHOW_ALERT: begin
                value_d = code_q;
                page_d  = 2'd2;
            end
            default: begin
                value_d = bcd_reg_q;
                page_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SHOW_BPM;
            cnt_q      <= '0;
            code_q     <= 8'h00;
            ack_q      <= 1'b0;
            value_q    <= 8'h00;
            page_q     <= 2'd0;
            bin_q      <= 8'h00;
            work_q     <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            bcd_reg_q  <= 8'h00;
            pend_q     <= 1'b0;
            pend_val_q <= 8'h00;
        end else begin
            // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            ack_q      <= ack_d;
            value_q    <= value_d;
            page_q     <= page_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            bcd_reg_q  <= bcd_reg_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign alert_ack = ack_q;
    assign value     = value_q;
    assign page      = page_q;
    assign bcd_busy  = busy_q;

endmodule

// File: tb/tb_seg_page_scheduler.sv
// Directed bench for seg_page_scheduler: a page/converter model checked every cycle,
// plus hand-computed expectations at the points that matter.
`timescale 1ns/1ps
module tb_seg_page_scheduler;
    localparam int DWELL = 20;
    localparam int ALERT = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic [3:0] mode;
    logic       hold;
    logic       alert_req;
    logic [7:0] alert_code;
    logic       alert_ack;
    logic [7:0] value;
    logic [1:0] page;
    logic       bcd_busy;

    int errors = 0;
    int checks = 0;

    seg_page_scheduler #(.DWELL_CYCLES(DWELL), .ALERT_CYCLES(ALERT)) dut (
        .clk(clk), .rst(rst), .bpm(bpm), .bpm_valid(bpm_valid), .mode(mode), .hold(hold),
        .alert_req(alert_req), .alert_code(alert_code), .alert_ack(alert_ack),
        .value(value), .page(page), .bcd_busy(bcd_busy)
    );

    always #41.667 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int b);
        if (b > 99) return 8'h99;
        return 8'(((b / 10) * 16) + (b % 10));
    endfunction

    // Model state: a conversion is "due in N edges"; a page is "N edges left to show".
    int         m_conv_left, m_job, m_pend, m_st, m_left;
    bit         m_has_pend;
    logic [7:0] m_bcd, m_code, m_value;
    logic [1:0] m_page;
    logic       m_ack;

    always @(posedge clk or posedge rst) begin : model
        int         conv_left, job, pend, st, left;
        bit         has_pend;
        logic [7:0] bcd, code;
        if (rst) begin
            m_conv_left <= 0; m_job <= 0; m_pend <= 0; m_has_pend <= 1'b0;
            m_st <= 0; m_left <= DWELL; m_bcd <= 8'h00; m_code <= 8'h00;
            m_value <= 8'h00; m_page <= 2'd0; m_ack <= 1'b0;
        end else begin
            conv_left = m_conv_left; job = m_job; pend = m_pend; has_pend = m_has_pend;
            st = m_st; left = m_left; bcd = m_bcd; code = m_code;

            m_value <= (st == 0) ? bcd : (st == 1) ? {4'hC, mode} : code;
            m_page  <= 2'(st);

            if (conv_left > 0) begin
                if (bpm_valid) begin has_pend = 1'b1; pend = int'(bpm); end
                conv_left--;
                if (conv_left == 0) bcd = to_bcd(job);
            end else if (bpm_valid) begin
                job = int'(bpm); conv_left = 8; has_pend = 1'b0;
            end else if (has_pend) begin
                job = pend; conv_left = 8; has_pend = 1'b0;
            end

            m_ack <= 1'b0;
            if (st == 2) begin
                left--;
                if (left == 0) begin st = 0; left = DWELL; end
            end else if (alert_req) begin
                st = 2; left = ALERT; code = alert_code; m_ack <= 1'b1;
            end else if (!hold) begin
                left--;
                if (left == 0) begin st = 1 - st; left = DWELL; end
            end

            m_conv_left <= conv_left; m_job <= job; m_pend <= pend; m_has_pend <= has_pend;
            m_st <= st; m_left <= left; m_bcd <= bcd; m_code <= code;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_value", value, m_value);
            check("model_page", 8'(page), 8'(m_page));
            check("model_ack", 8'(alert_ack), 8'(m_ack));
            check("model_busy", 8'(bcd_busy), 8'(m_conv_left > 0));
        end
    end

    task automatic strobe(input logic [7:0] b);
        bpm = b;
        bpm_valid = 1'b1;
        @(negedge clk);
        bpm_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bpm = 8'd0; bpm_valid = 1'b0; mode = 4'h3; hold = 1'b1;
        alert_req = 1'b0; alert_code = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_value", value, 8'h00);
        check("reset_page", 8'(page), 8'd0);
        check("reset_ack", 8'(alert_ack), 8'd0);
        check("reset_busy", 8'(bcd_busy), 8'd0);

        // Conversion latency and busy window (rotation frozen on the BPM page).
        strobe(8'd72);
        check("busy_first", 8'(bcd_busy), 8'd1);
        repeat (7) @(negedge clk);
        check("busy_eighth", 8'(bcd_busy), 8'd1);
        @(negedge clk);
        check("busy_cleared", 8'(bcd_busy), 8'd0);
        check("value_before_72", value, 8'h00);
        @(negedge clk);
        check("value_72", value, 8'h72);
        check("page_bpm", 8'(page), 8'd0);

        strobe(8'd150);
        repeat (9) @(negedge clk);
        check("value_sat_150", value, 8'h99);
        strobe(8'd9);
        repeat (9) @(negedge clk);
        check("value_09", value, 8'h09);

        // Strobes while busy: last pending sample wins, 61 is dropped.
        strobe(8'd60);
        repeat (2) @(negedge clk);
        strobe(8'd61);
        @(negedge clk);
        strobe(8'd88);
        repeat (3) @(negedge clk);
        check("value_still_09", value, 8'h09);
        @(negedge clk);
        check("value_60", value, 8'h60);
        repeat (8) @(negedge clk);
        check("value_60_held", value, 8'h60);
        @(negedge clk);
        check("value_88", value, 8'h88);

        // Dwell rotation, then a 15-clock hold stretching one dwell.
        hold = 1'b0;
        repeat (20) @(negedge clk);
        check("page_before_toggle", 8'(page), 8'd0);
        @(negedge clk);
        check("page_mode", 8'(page), 8'd1);
        check("value_mode", value, 8'hC3);
        repeat (20) @(negedge clk);
        check("page_back_bpm", 8'(page), 8'd0);
        repeat (4) @(negedge clk);
        hold = 1'b1;
        repeat (15) @(negedge clk);
        hold = 1'b0;
        repeat (15) @(negedge clk);
        check("page_held_dwell", 8'(page), 8'd0);
        @(negedge clk);
        check("page_mode_late", 8'(page), 8'd1);
        check("value_mode_late", value, 8'hC3);

        // Alert from the mode page; later code changes are ignored.
        alert_req = 1'b1; alert_code = 8'hE1;
        @(negedge clk);
        check("ack_pulse", 8'(alert_ack), 8'd1);
        alert_req = 1'b0;
        @(negedge clk);
        check("ack_single", 8'(alert_ack), 8'd0);
        check("value_alert", value, 8'hE1);
        check("page_alert", 8'(page), 8'd2);
        alert_code = 8'h00;
        repeat (8) @(negedge clk);
        check("value_alert_kept", value, 8'hE1);
        @(negedge clk);
        check("page_alert_last", 8'(page), 8'd2);
        @(negedge clk);
        check("page_after_alert", 8'(page), 8'd0);
        check("value_after_alert", value, 8'h88);

        // Continuous request: re-accepted the first clock after return.
        alert_code = 8'h5A; alert_req = 1'b1;
        @(negedge clk);
        check("ack_first", 8'(alert_ack), 8'd1);
        repeat (10) @(negedge clk);
        check("ack_none_in_alert", 8'(alert_ack), 8'd0);
        @(negedge clk);
        check("ack_reaccept", 8'(alert_ack), 8'd1);
        check("page_gap", 8'(page), 8'd0);
        @(negedge clk);
        check("page_realert", 8'(page), 8'd2);
        strobe(8'd200);
        strobe(8'd30);
        repeat (2) @(negedge clk);
        check("busy_before_rst", 8'(bcd_busy), 8'd1);

        // Asynchronous reset mid-alert and mid-conversion.
        #10 rst = 1'b1;
        #1;
        check("async_value", value, 8'h00);
        check("async_page", 8'(page), 8'd0);
        check("async_ack", 8'(alert_ack), 8'd0);
        check("async_busy", 8'(bcd_busy), 8'd0);
        alert_req = 1'b0; hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_pending_busy", 8'(bcd_busy), 8'd0);
        check("no_pending_value", value, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
